// File: rtl/regfile_wb_scheduler_if.sv
// Bundle for the writeback scheduler: issue-side hazard query, the two writeback
// requesters (ALU "a", load "m"), the register-file write port and the scoreboard view.
interface regfile_wb_scheduler_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  logic                        issue_valid;
  logic                        issue_wb;
  logic [ADDR_WIDTH-1:0]       issue_rd;
  logic [ADDR_WIDTH-1:0]       issue_rs1;
  logic [ADDR_WIDTH-1:0]       issue_rs2;
  logic                        issue_stall;

  logic                        a_valid;
  logic [ADDR_WIDTH-1:0]       a_rd;
  logic [DATA_WIDTH-1:0]       a_data;
  logic                        a_ready;

  logic                        m_valid;
  logic [ADDR_WIDTH-1:0]       m_rd;
  logic [DATA_WIDTH-1:0]       m_data;
  logic                        m_ready;

  logic                        rf_wen;
  logic [ADDR_WIDTH-1:0]       rf_rd;
  logic [DATA_WIDTH-1:0]       rf_wdata;
  logic [(1<<ADDR_WIDTH)-1:0]  busy;
  logic [ADDR_WIDTH:0]         pending_cnt;
  logic                        wb_unexpected;
  logic                        rr_favour_a;   // arbiter state, debug view

  modport master (
    output issue_valid, issue_wb, issue_rd, issue_rs1, issue_rs2,
    output a_valid, a_rd, a_data, m_valid, m_rd, m_data,
    input  issue_stall, a_ready, m_ready,
    input  rf_wen, rf_rd, rf_wdata, busy, pending_cnt, wb_unexpected, rr_favour_a
  );

  modport slave (
    input  issue_valid, issue_wb, issue_rd, issue_rs1, issue_rs2,
    input  a_valid, a_rd, a_data, m_valid, m_rd, m_data,
    output issue_stall, a_ready, m_ready,
    output rf_wen, rf_rd, rf_wdata, busy, pending_cnt, wb_unexpected, rr_favour_a
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Shares the register file's single write port between the ALU and load writeback
// paths, and tracks pending destination writes in a per-register scoreboard.
module regfile_wb_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wb_scheduler_if.slave bus
);
  localparam int NREG = 1 << ADDR_WIDTH;

  typedef enum logic {FAV_M = 1'b0, FAV_A = 1'b1} rr_t;

  rr_t                   rr_q, rr_d;
  logic                  grant_a, grant_m;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  issue_accept;
  logic [NREG-1:0]       busy_q, busy_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  rf_wen_q;
  logic [ADDR_WIDTH-1:0] rf_rd_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic                  unexp_q;

  // Handshake: a requester holds valid/rd/data stable until ready; a transfer
  // happens in any cycle where valid & ready, and ready is only ever high for
  // the single granted side.
  always_ff @(posedge clk) begin
    if (rst) rr_q <= FAV_M;
    else     rr_q <= rr_d;
  end

  always_comb begin
    rr_d    = rr_q;
    grant_a = 1'b0;
    grant_m = 1'b0;
    case ({bus.a_valid, bus.m_valid})
      2'b10: grant_a = 1'b1;
      2'b01: grant_m = 1'b1;
      2'b11: begin
        if (rr_q == FAV_A) begin
          grant_a = 1'b1;
          rr_d    = FAV_M;
        end else begin
          grant_m = 1'b1;
          rr_d    = FAV_A;
        end
      end
      default: ;
    endcase
  end

  // Stall looks only at registered busy; a write clearing this cycle does not bypass.
  always_comb begin
    bus.issue_stall = bus.issue_valid & (busy_q[bus.issue_rs1] | busy_q[bus.issue_rs2] |
                                         (bus.issue_wb & busy_q[bus.issue_rd]));
    issue_accept    = bus.issue_valid & ~bus.issue_stall;
  end

  always_comb begin
    xfer     = (bus.a_valid & grant_a) | (bus.m_valid & grant_m);
    sel_rd   = grant_a ? bus.a_rd   : bus.m_rd;
    sel_data = grant_a ? bus.a_data : bus.m_data;

    // Clear first so that a same-index set from issue wins.
    busy_d = busy_q;
    if (rf_wen_q) busy_d[rf_rd_q] = 1'b0;
    if (issue_accept && bus.issue_wb && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;

    cnt_d = '0;
    for (int i = 0; i < NREG; i++) cnt_d = cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      cnt_q      <= '0;
      rf_wen_q   <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      unexp_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      rf_wen_q <= xfer && (sel_rd != '0);
      unexp_q  <= xfer && (sel_rd != '0) && !busy_q[sel_rd];
      if (xfer) begin
        rf_rd_q    <= sel_rd;
        rf_wdata_q <= sel_data;
      end
    end
  end

  assign bus.a_ready       = grant_a;
  assign bus.m_ready       = grant_m;
  assign bus.rf_wen        = rf_wen_q;
  assign bus.rf_rd         = rf_rd_q;
  assign bus.rf_wdata      = rf_wdata_q;
  assign bus.busy          = busy_q;
  assign bus.pending_cnt   = cnt_q;
  assign bus.wb_unexpected = unexp_q;
  assign bus.rr_favour_a   = (rr_q == FAV_A);
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: hand-computed expectations plus a
// queue of expected register-file writes checked on every rf_wen.
module tb_regfile_wb_scheduler;
  localparam int AW = 5;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [AW+DW-1:0] exp_q[$];

  regfile_wb_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 1'b0; bus.issue_wb = 1'b0;
    bus.issue_rd = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
    bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
    bus.m_valid = 1'b0; bus.m_rd = '0; bus.m_data = '0;
  endtask

  task automatic issue_wr(input logic [AW-1:0] rd);
    bus.issue_valid = 1'b1; bus.issue_wb = 1'b1; bus.issue_rd = rd;
    bus.issue_rs1 = '0; bus.issue_rs2 = '0;
    tick();
    bus.issue_valid = 1'b0; bus.issue_wb = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // scoreboard: every write the file sees must be the next expected one
  always @(negedge clk) begin
    if (!rst && bus.rf_wen) begin
      if (exp_q.size() == 0) begin
        check("wb_extra", 64'(bus.rf_rd), 64'hFFFF);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check("wb_q_rd",   64'(bus.rf_rd), 64'(e[AW+DW-1:DW]));
        check("wb_q_data", bus.rf_wdata,   e[DW-1:0]);
      end
    end
  end

  initial begin
    idle_inputs();
    // reset then idle
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rst_busy",    64'(bus.busy), 64'h0);
    check("rst_pend",    64'(bus.pending_cnt), 64'h0);
    check("rst_wen",     64'(bus.rf_wen), 64'h0);
    check("rst_rd",      64'(bus.rf_rd), 64'h0);
    check("rst_wdata",   bus.rf_wdata, 64'h0);
    check("rst_unexp",   64'(bus.wb_unexpected), 64'h0);
    check("rst_a_ready", 64'(bus.a_ready), 64'h0);
    check("rst_m_ready", 64'(bus.m_ready), 64'h0);

    // RAW stall on x5 and its release
    bus.issue_valid = 1'b1; bus.issue_wb = 1'b1; bus.issue_rd = 5'd5;
    #1 check("t2_no_stall", 64'(bus.issue_stall), 64'h0);
    tick();
    check("t2_busy5", 64'(bus.busy), 64'h20);
    check("t2_pend1", 64'(bus.pending_cnt), 64'h1);
    bus.issue_wb = 1'b0; bus.issue_rd = '0; bus.issue_rs1 = 5'd5;
    bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 64'h1234;
    #1;
    check("t2_stall", 64'(bus.issue_stall), 64'h1);
    check("t2_a_ready", 64'(bus.a_ready), 64'h1);
    exp_q.push_back({5'd5, 64'h1234});
    tick();
    bus.a_valid = 1'b0;
    check("t2_wen", 64'(bus.rf_wen), 64'h1);
    check("t2_rd", 64'(bus.rf_rd), 64'h5);
    check("t2_wdata", bus.rf_wdata, 64'h1234);
    check("t2_unexp", 64'(bus.wb_unexpected), 64'h0);
    check("t2_stall_hold", 64'(bus.issue_stall), 64'h1);
    tick();
    check("t2_wen_off", 64'(bus.rf_wen), 64'h0);
    check("t2_busy_clr", 64'(bus.busy), 64'h0);
    check("t2_stall_drop", 64'(bus.issue_stall), 64'h0);
    idle_inputs();

    // both requesters valid after reset: M first, then A
    do_reset();
    issue_wr(5'd3);
    issue_wr(5'd7);
    check("t3_pend2", 64'(bus.pending_cnt), 64'h2);
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 64'hAAAA;
    bus.m_valid = 1'b1; bus.m_rd = 5'd7; bus.m_data = 64'hBBBB;
    #1;
    check("t3_m_first", 64'(bus.m_ready), 64'h1);
    check("t3_a_wait", 64'(bus.a_ready), 64'h0);
    exp_q.push_back({5'd7, 64'hBBBB});
    tick();
    bus.m_valid = 1'b0;
    #1;
    check("t3_a_second", 64'(bus.a_ready), 64'h1);
    check("t3_wr7", 64'(bus.rf_rd), 64'h7);
    exp_q.push_back({5'd3, 64'hAAAA});
    tick();
    bus.a_valid = 1'b0;
    check("t3_wr3", 64'(bus.rf_rd), 64'h3);
    check("t3_wen3", 64'(bus.rf_wen), 64'h1);
    check("t3_busy_mid", 64'(bus.busy), 64'h8);
    tick();
    check("t3_busy_end", 64'(bus.busy), 64'h0);
    check("t3_pend_end", 64'(bus.pending_cnt), 64'h0);
    // pointer flipped only on the both-valid cycle, so A wins the next tie
    bus.a_valid = 1'b1; bus.a_rd = '0; bus.a_data = 64'h1;
    bus.m_valid = 1'b1; bus.m_rd = '0; bus.m_data = 64'h2;
    #1;
    check("t3_tie_a", 64'(bus.a_ready), 64'h1);
    check("t3_tie_m", 64'(bus.m_ready), 64'h0);
    tick();
    idle_inputs();

    // write to x0: handshake completes, nothing reaches the file
    bus.a_valid = 1'b1; bus.a_rd = '0; bus.a_data = 64'hFF;
    #1 check("t4_a_ready", 64'(bus.a_ready), 64'h1);
    tick();
    bus.a_valid = 1'b0;
    check("t4_wen", 64'(bus.rf_wen), 64'h0);
    check("t4_busy", 64'(bus.busy), 64'h0);
    check("t4_unexp", 64'(bus.wb_unexpected), 64'h0);
    check("t4_wdata", bus.rf_wdata, 64'hFF);

    // unexpected write to non-busy x9
    bus.m_valid = 1'b1; bus.m_rd = 5'd9; bus.m_data = 64'h9999;
    #1 check("t5_m_ready", 64'(bus.m_ready), 64'h1);
    exp_q.push_back({5'd9, 64'h9999});
    tick();
    bus.m_valid = 1'b0;
    check("t5_wen", 64'(bus.rf_wen), 64'h1);
    check("t5_rd", 64'(bus.rf_rd), 64'h9);
    check("t5_unexp", 64'(bus.wb_unexpected), 64'h1);
    tick();
    check("t5_unexp_off", 64'(bus.wb_unexpected), 64'h0);
    check("t5_busy", 64'(bus.busy), 64'h0);

    // reset while A is granted
    issue_wr(5'd4);
    issue_wr(5'd6);
    check("t6_pend2", 64'(bus.pending_cnt), 64'h2);
    check("t6_busy", 64'(bus.busy), 64'h50);
    bus.a_valid = 1'b1; bus.a_rd = 5'd4; bus.a_data = 64'h44;
    #1 check("t6_a_ready", 64'(bus.a_ready), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.a_valid = 1'b0;
    check("t6_busy_clr", 64'(bus.busy), 64'h0);
    check("t6_pend_clr", 64'(bus.pending_cnt), 64'h0);
    check("t6_wen", 64'(bus.rf_wen), 64'h0);
    tick();
    check("t6_wen_next", 64'(bus.rf_wen), 64'h0);

    tick();
    check("exp_q_empty", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
